// File: rtl/lfsr_bist_ctrl.sv
// lfsr_bist_ctrl: BIST sequencer for a 3-bit Fibonacci pattern LFSR.
// It resets and optionally seeds the LFSR, runs it for n_pat patterns,
// compacts the CUT response into a MISR signature and compares that
// signature against a golden value.
// Optional build macro: POLY_SWEEP_EN. When it is defined, a second pass
// runs with the inverted polynomial, and the signature accumulates across
// both passes.
//
// state | meaning
// IDLE  | LFSR held in reset, waiting for start
// INIT  | signature cleared (first pass only), counter loaded
// SEED  | LFSR released, seed and polynomial applied
// RUN   | one pattern compacted per cycle
// CMP   | signature compared against golden
module lfsr_bist_ctrl #(
  parameter int              CNT_W    = 8,
  parameter int              RESP_W   = 3,
  parameter int              SIG_W    = 8,
  parameter logic [SIG_W-1:0] SIG_TAPS = 8'h1D
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_pat,
  input  logic              poly_sel,
  input  logic              seed_sel,
  input  logic [SIG_W-1:0]  golden,
  input  logic [RESP_W-1:0] resp,
  output logic              lfsr_rst,
  output logic              lfsr_seed,
  output logic              lfsr_poly,
  output logic              pat_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_SEED = 3'd2,
    S_RUN  = 3'd3,
    S_CMP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_lat_q, n_lat_d;
  logic               poly_lat_q, poly_lat_d;
  logic               seed_lat_q, seed_lat_d;
  logic [SIG_W-1:0]   golden_lat_q, golden_lat_d;
  logic [SIG_W-1:0]   signature_q, signature_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               lfsr_rst_q, lfsr_rst_d;
  logic               lfsr_seed_q, lfsr_seed_d;
  logic               lfsr_poly_q, lfsr_poly_d;
  logic               pat_valid_q, pat_valid_d;
  logic               busy_q, busy_d;
  logic               poly_flip_d;
  logic [SIG_W-1:0]   sig_step;
`ifdef POLY_SWEEP_EN
  logic               pass2_q, pass2_d;
`endif

  // One MISR step: shift left, fold the MSB back through the taps, add resp.
  always_comb begin
    sig_step = {signature_q[SIG_W-2:0], 1'b0}
             ^ (signature_q[SIG_W-1] ? SIG_TAPS : '0)
             ^ SIG_W'(resp);
  end

  // Next-state logic; the outputs are derived from the next state so they
  // come straight out of flops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_lat_d      = n_lat_q;
    poly_lat_d   = poly_lat_q;
    seed_lat_d   = seed_lat_q;
    golden_lat_d = golden_lat_q;
    signature_d  = signature_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
`ifdef POLY_SWEEP_EN
    pass2_d      = pass2_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_lat_d      = n_pat;
          poly_lat_d   = poly_sel;
          seed_lat_d   = seed_sel;
          golden_lat_d = golden;
          state_d      = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d  = n_lat_q;
        pass_d = 1'b0;
`ifdef POLY_SWEEP_EN
        if (!pass2_q) signature_d = '0;
`else
        signature_d = '0;
`endif
        state_d = S_SEED;
      end
      S_SEED: begin
        state_d = (cnt_q == '0) ? S_CMP : S_RUN;
      end
      S_RUN: begin
        signature_d = sig_step;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_CMP;
      end
      S_CMP: begin
`ifdef POLY_SWEEP_EN
        if (!pass2_q) begin
          pass2_d = 1'b1;
          state_d = S_INIT;
        end else begin
          pass2_d = 1'b0;
          pass_d  = (signature_q == golden_lat_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`else
        pass_d  = (signature_q == golden_lat_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Abort leaves the partial signature visible for debug.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      pass_d      = 1'b0;
      done_d      = 1'b0;
      signature_d = signature_q;
      cnt_d       = cnt_q;
`ifdef POLY_SWEEP_EN
      pass2_d     = 1'b0;
`endif
    end

`ifdef POLY_SWEEP_EN
    poly_flip_d = pass2_d;
`else
    poly_flip_d = 1'b0;
`endif

    lfsr_rst_d  = (state_d == S_IDLE) || (state_d == S_INIT);
    lfsr_seed_d = (state_d == S_SEED) && seed_lat_d;
    lfsr_poly_d = ((state_d == S_SEED) || (state_d == S_RUN) || (state_d == S_CMP))
                  ? (poly_lat_d ^ poly_flip_d) : 1'b0;
    pat_valid_d = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      n_lat_q      <= '0;
      poly_lat_q   <= 1'b0;
      seed_lat_q   <= 1'b0;
      golden_lat_q <= '0;
      signature_q  <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      lfsr_rst_q   <= 1'b1;
      lfsr_seed_q  <= 1'b0;
      lfsr_poly_q  <= 1'b0;
      pat_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef POLY_SWEEP_EN
      pass2_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_lat_q      <= n_lat_d;
      poly_lat_q   <= poly_lat_d;
      seed_lat_q   <= seed_lat_d;
      golden_lat_q <= golden_lat_d;
      signature_q  <= signature_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      lfsr_rst_q   <= lfsr_rst_d;
      lfsr_seed_q  <= lfsr_seed_d;
      lfsr_poly_q  <= lfsr_poly_d;
      pat_valid_q  <= pat_valid_d;
      busy_q       <= busy_d;
`ifdef POLY_SWEEP_EN
      pass2_q      <= pass2_d;
`endif
    end
  end

  assign lfsr_rst  = lfsr_rst_q;
  assign lfsr_seed = lfsr_seed_q;
  assign lfsr_poly = lfsr_poly_q;
  assign pat_valid = pat_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = signature_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl (default build, single pass).
module tb_lfsr_bist_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] n_pat = '0;
  logic       poly_sel = 1'b0;
  logic       seed_sel = 1'b0;
  logic [7:0] golden = '0;
  logic [2:0] resp = '0;
  logic       lfsr_rst, lfsr_seed, lfsr_poly, pat_valid, busy, done, pass;
  logic [7:0] signature;

  int checks = 0;
  int errors = 0;

  lfsr_bist_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .n_pat(n_pat),
    .poly_sel(poly_sel), .seed_sel(seed_sel), .golden(golden), .resp(resp),
    .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed), .lfsr_poly(lfsr_poly),
    .pat_valid(pat_valid), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       n;
    bit       poly;
    bit       seed;
    bit [7:0] gold;
    bit [2:0] rsp;
    bit [7:0] exp_sig;
    bit       exp_pass;
  } vec_t;

  vec_t vecs[8];

  // statistics gathered by run_case
  int pv_cnt, pv_first, done_cnt, done_cyc, seed_cnt, seed_cyc;
  int poly_cnt, poly_first, poly_last, rst_low_cnt, busy_cnt, last_busy_cyc;
  int sig_at_done, pass_at_done, sig_final, pass_final, sig_early;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Start a run in cycle 0 and observe cycles 1..max_cyc.
  // abort_cyc: cycle during which abort is high (0 = together with start, -1 none).
  // restart_cyc: cycle during which start is pulsed again with a different n_pat.
  task automatic run_case(input int n, input bit poly, input bit seed, input bit [7:0] gold,
                          input bit [2:0] rsp, input int abort_cyc, input int restart_cyc,
                          input int max_cyc);
    @(posedge CLK); #1;
    n_pat = 8'(n); poly_sel = poly; seed_sel = seed; golden = gold; resp = rsp;
    start = 1'b1; abort = (abort_cyc == 0);
    pv_cnt = 0; pv_first = -1; done_cnt = 0; done_cyc = -1; seed_cnt = 0; seed_cyc = -1;
    poly_cnt = 0; poly_first = -1; poly_last = -1; rst_low_cnt = 0; busy_cnt = 0;
    last_busy_cyc = -1; sig_at_done = -1; pass_at_done = -1; sig_early = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge CLK); #1;
      start = 1'b0; abort = 1'b0;
      if (pat_valid) begin pv_cnt++; if (pv_first < 0) pv_first = c; end
      if (done) begin done_cnt++; done_cyc = c; sig_at_done = signature; pass_at_done = pass; end
      if (lfsr_seed) begin seed_cnt++; seed_cyc = c; end
      if (lfsr_poly) begin poly_cnt++; if (poly_first < 0) poly_first = c; poly_last = c; end
      if (!lfsr_rst) rst_low_cnt++;
      if (busy) begin busy_cnt++; last_busy_cyc = c; end
      if (c == 8) sig_early = signature;
      if (c == abort_cyc) abort = 1'b1;
      if (c == restart_cyc) begin start = 1'b1; n_pat = 8'd2; end
    end
    sig_final = signature;
    pass_final = pass;
  endtask

  initial begin
    //            n    poly seed gold   rsp     sig    pass
    vecs[0] = '{0,   0,   0,   8'h00, 3'b000, 8'h00, 1};
    vecs[1] = '{4,   0,   0,   8'h0F, 3'b001, 8'h0F, 1};
    vecs[2] = '{4,   1,   0,   8'h0E, 3'b001, 8'h0F, 0};
    vecs[3] = '{1,   0,   1,   8'h05, 3'b101, 8'h05, 1};
    vecs[4] = '{6,   1,   1,   8'hBD, 3'b111, 8'hBD, 1};
    vecs[5] = '{9,   0,   0,   8'hE2, 3'b001, 8'hE2, 1};
    vecs[6] = '{10,  1,   1,   8'h00, 3'b000, 8'h00, 1};
    vecs[7] = '{255, 1,   0,   8'h00, 3'b000, 8'h00, 1};

    #12;
    check("reset_lfsr_rst", lfsr_rst, 1);
    check("reset_busy", busy, 0);
    check("reset_pass", pass, 0);
    check("reset_sig", signature, 0);
    check("reset_poly", lfsr_poly, 0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      run_case(v.n, v.poly, v.seed, v.gold, v.rsp, -1, -1, v.n + 8);
      check($sformatf("v%0d_pv_cnt", i), pv_cnt, v.n);
      check($sformatf("v%0d_pv_first", i), pv_first, (v.n == 0) ? -1 : 3);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_done_cyc", i), done_cyc, v.n + 4);
      check($sformatf("v%0d_sig", i), sig_at_done, v.exp_sig);
      check($sformatf("v%0d_pass", i), pass_at_done, v.exp_pass);
      check($sformatf("v%0d_seed_cnt", i), seed_cnt, v.seed ? 1 : 0);
      if (v.seed) check($sformatf("v%0d_seed_cyc", i), seed_cyc, 2);
      check($sformatf("v%0d_poly_cnt", i), poly_cnt, v.poly ? v.n + 2 : 0);
      if (v.poly) check($sformatf("v%0d_poly_first", i), poly_first, 2);
      check($sformatf("v%0d_busy_cnt", i), busy_cnt, v.n + 3);
      check($sformatf("v%0d_rst_low", i), rst_low_cnt, v.n + 2);
      check($sformatf("v%0d_sig_held", i), sig_final, v.exp_sig);
      check($sformatf("v%0d_pass_held", i), pass_final, v.exp_pass);
    end

    // abort in cycle 6 of a 10-pattern run with seed and poly
    run_case(10, 1, 1, 8'h00, 3'b011, 6, -1, 20);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_last_busy", last_busy_cyc, 6);
    check("abort_seed_cyc", seed_cyc, 2);
    check("abort_poly_last", poly_last, 6);
    check("abort_pass", pass_final, 0);
    check("abort_lfsr_rst", lfsr_rst, 1);
    check("abort_sig_hold", sig_final, sig_early);

    // start pulsed again in cycle 5 with a different n_pat: ignored
    run_case(4, 0, 0, 8'h0F, 3'b001, -1, 5, 14);
    check("restart_done_cnt", done_cnt, 1);
    check("restart_done_cyc", done_cyc, 8);
    check("restart_pv_cnt", pv_cnt, 4);
    check("restart_sig", sig_at_done, 8'h0F);
    check("restart_pass", pass_at_done, 1);

    // abort together with start in IDLE: start wins
    run_case(2, 0, 0, 8'h03, 3'b001, 0, -1, 10);
    check("abort_start_done", done_cnt, 1);
    check("abort_start_pv", pv_cnt, 2);
    check("abort_start_sig", sig_at_done, 8'h03);

    // asynchronous reset in the middle of RUN
    @(posedge CLK); #1;
    n_pat = 8'd10; resp = 3'b001; start = 1'b1;
    repeat (5) begin @(posedge CLK); #1; start = 1'b0; end
    check("midrun_busy_before", busy, 1);
    RST = 1'b0;
    #1;
    check("midrun_lfsr_rst", lfsr_rst, 1);
    check("midrun_busy", busy, 0);
    check("midrun_pv", pat_valid, 0);
    check("midrun_sig", signature, 0);
    check("midrun_poly", lfsr_poly, 0);
    check("midrun_done", done, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("post_reset_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_bist_ctrl.md
Name: lfsr_bist_ctrl

Overview:
Sequencer for the 3-bit Fibonacci pattern LFSR (Seed/Poly/RST inputs, x0..x2 outputs) used as a built-in self-test source.
- On a start request it resets and optionally seeds the LFSR, selects its polynomial and runs it for a programmed number of patterns.
- During the run it compacts the circuit-under-test response into a MISR signature and compares that signature against a golden value.
- It sits between the test-control registers and the LFSR/CUT pair.

Parameters:
CNT_W, 8, width of pattern counter and n_pat
RESP_W, 3, CUT response width (≤ SIG_W)
SIG_W, 8, MISR signature width
SIG_TAPS, 8'h1D, MISR feedback tap mask (SIG_W bits)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-low
start  in  1  run request, sampled in IDLE only
abort  in  1  cancel the current run
n_pat  in  CNT_W  patterns per run, sampled with start
poly_sel  in  1  LFSR polynomial select, sampled with start
seed_sel  in  1  1 = load all-ones seed after LFSR reset
golden  in  SIG_W  expected signature, sampled with start
resp  in  RESP_W  CUT response to the current pattern
lfsr_rst  out  1  drives LFSR RST (active-high, synchronous at LFSR)
lfsr_seed  out  1  drives LFSR Seed
lfsr_poly  out  1  drives LFSR Poly
pat_valid  out  1  high in each cycle whose resp is compacted
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the run completes
pass  out  1  signature == golden; held until the next start
signature  out  SIG_W  MISR value; held after the run

Behaviour:
- Reset (RST=0, async): state=IDLE, lfsr_rst=1, lfsr_seed=0, lfsr_poly=0, pat_valid=0, busy=0, done=0, pass=0, signature=0, counter=0.
- FSM states: IDLE, INIT, SEED, RUN, CMP.
- IDLE: lfsr_rst=1. start=1 → latch n_pat, poly_sel, seed_sel and golden; go to INIT. start while busy is ignored.
- INIT (1 cycle): lfsr_rst=1, signature cleared to 0, counter loaded with the latched n_pat. Next state SEED.
- SEED (1 cycle): lfsr_rst=0, lfsr_seed=seed_sel, lfsr_poly=poly_sel. Next state RUN, or CMP if n_pat==0.
- RUN: lfsr_rst=0, lfsr_seed=0, pat_valid=1.
  - Each cycle: signature ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? SIG_TAPS : 0) ^ zero-extended resp.
  - Counter decrements each cycle; leave to CMP in the cycle the counter equals 1. Exactly n_pat compaction cycles.
- CMP (1 cycle): pass ← (signature==golden); done=1 in the following cycle (registered); return to IDLE.
- Latency: start high in cycle 0 → first pat_valid in cycle 3 → done in cycle 3+n_pat+1 (n_pat=0: done in cycle 4).
- lfsr_poly holds the latched value from SEED through CMP; it is 0 in IDLE.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - No done pulse; pass cleared; signature holds its partial value.
  - abort and start together in IDLE: start wins, abort ignored.
- pass/signature are not cleared by done; they change only at INIT, CMP, abort or reset.
- Reset asserted mid-run: immediate return to the reset values; the LFSR is forced to reset via lfsr_rst=1.
- n_pat=2^CNT_W-1 is legal; the counter never wraps.

Optional Feature:
POLY_SWEEP_EN
- Defined: after the first pass's CMP the block does not go to IDLE.
  - It re-enters INIT with lfsr_poly=~poly_sel and runs a second n_pat-pattern pass.
  - Signature is NOT cleared on the second INIT, so it accumulates across both passes.
  - pass and done are produced only after the second CMP; total latency 2*(n_pat+3)+1.
  - abort is honoured in either pass.
- Undefined: single pass as described above; no pass-tracking register is present.

Test Plan:
1. Reset with RST=0 mid-RUN → all outputs at reset values within the same cycle; lfsr_rst=1.
2. start, n_pat=0, golden=8'h00 → no pat_valid; done in cycle 4; pass=1; signature=8'h00.
3. start, n_pat=4, resp held at 3'b001 → pat_valid for exactly 4 cycles; signature=8'h0F; with golden=8'h0F, pass=1 and done in cycle 8.
4. Same as 3 with golden=8'h0E → pass=0, signature=8'h0F, done still pulses once.
5. start, n_pat=10, seed_sel=1, poly_sel=1 → lfsr_seed=1 only in cycle 2; lfsr_poly=1 cycles 2..13; abort in cycle 6 → IDLE in cycle 7, no done, pass=0.
6. start pulsed again while busy (cycle 5 of an n_pat=4 run) → ignored: one done only, and the latched n_pat is unchanged.
